// File: rtl/adv7513_pkg.sv
// Shared types for the ADV7513 register dump block: FSM state encoding,
// register address/data widths and the result-entry layout.
package adv7513_pkg;

  localparam int REG_ADDR_W = 8;
  localparam int REG_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STORE  = 3'd3,
    ST_FINISH = 3'd4
  } dump_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } reg_entry_t;

endpackage

// File: rtl/adv7513_dump_fifo.sv
// First-word fall-through result FIFO. A push is accepted while full when a
// pop happens in the same cycle, so the producer never has to drop an entry.
module adv7513_dump_fifo
  import adv7513_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  reg_entry_t push_entry,
  output logic       push_ready,
  output logic       pop_valid,
  output reg_entry_t pop_entry,
  input  logic       pop
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 4 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("adv7513_dump_fifo: FIFO_DEPTH must be a power of two in 4..64");
  end

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  reg_entry_t     mem_q [FIFO_DEPTH];
  logic           empty, full, do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    do_pop     = pop && !empty;
    push_ready = !full || do_pop;
    do_push    = push && push_ready;
    wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    pop_valid  = !empty;
    pop_entry  = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_entry;
  end

endmodule

// File: rtl/adv7513_reg_dump.sv
// Walks an inclusive (wrapping) register address range through an external
// read stage and streams {addr, data} results out of a FWFT FIFO.
// Optional per-read abort counter: define ADV7513_REG_DUMP_TIMEOUT_EN.
module adv7513_reg_dump
  import adv7513_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [REG_ADDR_W-1:0] first_addr,
  input  logic [REG_ADDR_W-1:0] last_addr,
  output logic                  rd_start,
  output logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  rd_done,
  input  logic [REG_DATA_W-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] out_addr,
  output logic [REG_DATA_W-1:0] out_data,
  output logic                  busy,
  output logic                  dump_done,
  output logic                  timeout_err,
  output dump_state_e           dbg_state
);

  // Handshake: a result transfers on every rising clk edge where
  // out_valid && out_ready; out_addr/out_data hold the head until then.

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("adv7513_reg_dump: TIMEOUT_CYCLES must be at least 1");
  end

  dump_state_e           state_q, state_d;
  logic [REG_ADDR_W-1:0] cur_q, cur_d;
  logic [REG_ADDR_W-1:0] last_q, last_d;
  logic [REG_DATA_W-1:0] data_q, data_d;
  logic                  done_prev_q, done_prev_d;
  logic                  rd_edge, tmo_hit;
  logic                  fifo_push, fifo_push_ready;
  reg_entry_t            fifo_head;

  // done_prev tracks rd_done every cycle, so a level still high from the
  // previous read at ISSUE is seen as "already high" in WAIT, not as an edge.
  assign rd_edge = rd_done && !done_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      last_q      <= '0;
      data_q      <= '0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      data_q      <= data_d;
      done_prev_q <= done_prev_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    data_d      = data_q;
    done_prev_d = rd_done;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          cur_d   = first_addr;
          last_d  = last_addr;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (rd_edge) begin
          data_d  = rd_data;
          state_d = ST_STORE;
        end else if (tmo_hit) begin
          state_d = ST_FINISH;
        end
      end
      ST_STORE: begin
        if (fifo_push_ready) begin
          if (cur_q == last_q) begin
            state_d = ST_FINISH;
          end else begin
            cur_d   = cur_q + 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_start  = (state_q == ST_ISSUE);
    busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_STORE);
    dump_done = (state_q == ST_FINISH);
    fifo_push = (state_q == ST_STORE);
    rd_addr   = cur_q;
    out_addr  = fifo_head.addr;
    out_data  = fifo_head.data;
    dbg_state = state_q;
  end

`ifdef ADV7513_REG_DUMP_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  // tmo_cnt equals the number of WAIT cycles already spent on this read.
  assign tmo_hit     = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_q;

  always_comb begin
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = timeout_err_q;
    if (state_q == ST_ISSUE) tmo_cnt_d = '0;
    else if (state_q == ST_WAIT) tmo_cnt_d = tmo_cnt_q + 1'b1;
    if (state_q == ST_IDLE && go) timeout_err_d = 1'b0;
    else if (state_q == ST_WAIT && !rd_edge && tmo_hit) timeout_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  adv7513_dump_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_entry({cur_q, data_q}),
    .push_ready(fifo_push_ready),
    .pop_valid (out_valid),
    .pop_entry (fifo_head),
    .pop       (out_ready)
  );

endmodule

// File: tb/tb_adv7513_reg_dump.sv
// Bench for adv7513_reg_dump: randomized read-stage model, address-range
// expectation model and output scoreboard. Timeout case needs ADV7513_REG_DUMP_TIMEOUT_EN.
module tb_adv7513_reg_dump;
  import adv7513_pkg::*;

  localparam int FIFO_DEPTH     = 4;
  localparam int TIMEOUT_CYCLES = 100;

  logic        clk = 1'b0;
  logic        reset, go;
  logic [7:0]  first_addr, last_addr;
  logic        rd_start;
  logic [7:0]  rd_addr;
  logic        rd_done;
  logic [7:0]  rd_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_addr, out_data;
  logic        busy, dump_done, timeout_err;
  dump_state_e dbg_state;

  logic [15:0] exp_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [7:0]  rd_mem [256];
  int          n_cmp = 0, n_err = 0;
  int          done_cnt = 0, rd_cnt = 0;
  int          ready_mode = 1, hold_cycles = 0;
  bit          never_done = 1'b0;

  adv7513_reg_dump #(
    .FIFO_DEPTH    (FIFO_DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rd_start   (rd_start),
    .rd_addr    (rd_addr),
    .rd_done    (rd_done),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .busy       (busy),
    .dump_done  (dump_done),
    .timeout_err(timeout_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t reached, required finish earlier", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Expected behaviour from the range rule: inclusive, 8-bit wrapping walk.
  task automatic expect_dump(input logic [7:0] f, input logic [7:0] l, input bit with_data);
    logic [7:0] a;
    a = f;
    forever begin
      exp_rd_q.push_back(a);
      if (with_data) exp_q.push_back({a, rd_mem[a]});
      if (a == l) break;
      a = a + 8'd1;
    end
  endtask

  task automatic pulse_go(input logic [7:0] f, input logic [7:0] l);
    @(negedge clk);
    first_addr = f;
    last_addr  = l;
    go         = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    int base;
    base = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != base) seen = 1'b1;
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    repeat (2) @(negedge clk);
    #1;
    check("drain_results_left", exp_q.size(), 0);
    check("drain_reads_left", exp_rd_q.size(), 0);
  endtask

  task automatic run_dump(input logic [7:0] f, input logic [7:0] l);
    int d0;
    bit seen;
    d0 = done_cnt;
    expect_dump(f, l, 1'b1);
    pulse_go(f, l);
    wait_done(4000, seen);
    check("dump_done_seen", seen, 1);
    check("busy_low_at_done", busy, 0);
    check("timeout_err_clear", timeout_err, 0);
    drain(600);
    check("dump_done_once", done_cnt - d0, 1);
  endtask

  // ---------------- read-stage model ----------------
  initial begin : read_model
    logic [7:0] a;
    rd_done = 1'b0;
    rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rd_start === 1'b1) begin
        a = rd_addr;
        repeat (hold_cycles) @(negedge clk);
        rd_done = 1'b0;
        if (!never_done) begin
          repeat ($urandom_range(1, 4)) @(negedge clk);
          rd_data = rd_mem[a];
          rd_done = 1'b1;
        end
      end
    end
  end

  // ---------------- monitors / scoreboard ----------------
  initial begin : read_monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (dump_done === 1'b1) done_cnt++;
      if (rd_start === 1'b1) begin
        rd_cnt++;
        if (exp_rd_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rd_addr_unexpected: got read of %02h, required no read", rd_addr);
        end else begin
          e = exp_rd_q.pop_front();
          check("rd_addr_seq", rd_addr, e);
        end
      end
    end
  end

  initial begin : out_monitor
    logic [15:0] e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid === 1'b1 && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL out_unexpected: got %02h/%02h, required no result", out_addr, out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_entry", {out_addr, out_data}, e);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    bit          seen;
    int          d0, r0;
    logic [7:0]  f, l;

    reset = 1'b1;
    go = 1'b0;
    first_addr = 8'h00;
    last_addr = 8'h00;
    for (int i = 0; i < 256; i++) rd_mem[i] = 8'(i) ^ 8'hA5;

    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {rd_start, rd_addr, busy, dump_done, timeout_err,
                            out_valid, out_addr, out_data}, 0);
    check("reset_state", dbg_state, ST_IDLE);
    @(negedge clk);
    reset = 1'b0;

    // Basic scan with addr^A5 data.
    ready_mode = 1;
    run_dump(8'h00, 8'h03);

    // Wrapping scan.
    run_dump(8'hFE, 8'h01);

    // FIFO fills with the sink stalled; dump must park in STORE.
    ready_mode = 0;
    d0 = done_cnt;
    r0 = rd_cnt;
    expect_dump(8'h00, 8'h07, 1'b1);
    pulse_go(8'h00, 8'h07);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (rd_cnt - r0 == 5 && dbg_state == ST_STORE) seen = 1'b1;
    end
    check("stall_reached", seen, 1);
    repeat (10) @(negedge clk);
    #1;
    check("stall_state", dbg_state, ST_STORE);
    check("stall_reads", rd_cnt - r0, 5);
    check("stall_no_done", done_cnt - d0, 0);
    check("stall_head", {out_valid, out_addr, out_data}, {1'b1, exp_q[0]});
    ready_mode = 1;
    wait_done(2000, seen);
    check("stall_done_seen", seen, 1);
    drain(600);
    check("stall_done_once", done_cnt - d0, 1);

    // rd_done still high from the previous read: no advance until a new edge.
    d0 = done_cnt;
    hold_cycles = 6;
    expect_dump(8'h30, 8'h30, 1'b1);
    pulse_go(8'h30, 8'h30);
    repeat (4) @(negedge clk);
    #1;
    check("hold_no_advance", dbg_state, ST_WAIT);
    check("hold_busy", busy, 1);
    hold_cycles = 0;
    wait_done(2000, seen);
    check("hold_done_seen", seen, 1);
    drain(600);
    check("hold_done_once", done_cnt - d0, 1);

`ifdef ADV7513_REG_DUMP_TIMEOUT_EN
    // Read stage never answers: abort after TIMEOUT_CYCLES with nothing stored.
    never_done = 1'b1;
    d0 = done_cnt;
    expect_dump(8'h40, 8'h40, 1'b0);
    pulse_go(8'h40, 8'h45);
    repeat (60) @(negedge clk);
    #1;
    check("tmo_not_yet", {busy, timeout_err}, 2'b10);
    wait_done(300, seen);
    check("tmo_done_seen", seen, 1);
    check("tmo_err_set", timeout_err, 1);
    check("tmo_fifo_empty", out_valid, 0);
    never_done = 1'b0;
    drain(50);
    check("tmo_done_once", done_cnt - d0, 1);
`endif

    // Reset while waiting on a read in a 16-register dump.
    ready_mode = 1;
    expect_dump(8'h10, 8'h1F, 1'b1);
    r0 = rd_cnt;
    pulse_go(8'h10, 8'h1F);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (rd_cnt - r0 >= 3 && dbg_state == ST_WAIT) seen = 1'b1;
    end
    check("abort_reached_wait", seen, 1);
    @(negedge clk);
    reset = 1'b1;
    d0 = done_cnt;
    #1;
    check("abort_outputs", {rd_start, rd_addr, busy, dump_done, timeout_err,
                            out_valid, out_addr, out_data}, 0);
    check("abort_state", dbg_state, ST_IDLE);
    exp_q.delete();
    exp_rd_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_fifo_empty", out_valid, 0);
    run_dump(8'h20, 8'h22);

    // Randomized ranges, data and sink back-pressure.
    ready_mode = 2;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 256; i++) rd_mem[i] = 8'($urandom_range(0, 255));
      f = 8'($urandom_range(0, 255));
      l = f + 8'($urandom_range(0, 11));
      run_dump(f, l);
    end
    check("final_timeout_err", timeout_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adv7513_reg_dump.md
ADV7513_REG_DUMP -- requirements
Module: adv7513_reg_dump

Interface
REQ-001 Parameter FIFO_DEPTH, 16, result-buffer entries; SHALL be a power of two, 4..64.
REQ-002 Parameter TIMEOUT_CYCLES, 1000000, clk cycles allowed per register read before abort.
REQ-003 clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 go  input  1  single-cycle pulse that starts a dump.
REQ-006 first_addr  input  8  first register address to read.
REQ-007 last_addr  input  8  last register address to read, inclusive.
REQ-008 rd_start  output  1  start pulse to the register-read stage.
REQ-009 rd_addr  output  8  register address presented to the read stage.
REQ-010 rd_done  input  1  read-stage done level; held high until the next read begins.
REQ-011 rd_data  input  8  register value from the read stage, valid while rd_done is high.
REQ-012 out_valid / out_ready  output / input  1 / 1  result-stream handshake.
REQ-013 out_addr, out_data  output  8, 8  address and value of the head result.
REQ-014 busy  output  1  high from go acceptance until the dump completes.
REQ-015 dump_done  output  1  one-cycle pulse when the dump ends.
REQ-016 timeout_err  output  1  sticky flag; cleared by the next accepted go.

Function
REQ-017 States: IDLE, ISSUE, WAIT, STORE, FINISH.
- IDLE: go=1 -> latch first_addr/last_addr, cur=first_addr, busy=1, -> ISSUE.
- go is ignored while busy=1.
REQ-018 ISSUE: rd_start=1 for exactly one cycle, rd_addr=cur, arm a rising-edge detector on rd_done, -> WAIT.
REQ-019 rd_addr SHALL hold cur from ISSUE through STORE.
REQ-020 WAIT: the first 0->1 transition of rd_done after ISSUE -> STORE, with rd_data captured that cycle.
- A level already high at ISSUE SHALL NOT count as done.
REQ-021 STORE: if the FIFO is not full, push {cur, captured data}.
- If cur==last -> FINISH; else cur=cur+1 (8-bit wrap, 0xFF->0x00) -> ISSUE.
- If the FIFO is full, remain in STORE; no entry is dropped.
REQ-022 last_addr < first_addr SHALL scan through the wrap, e.g. 0xFE,0xFF,0x00. first==last reads one register.
REQ-023 FINISH: dump_done=1 for one cycle, busy=0, -> IDLE.
REQ-024 FIFO: first-word fall-through; out_valid = not empty; pop on out_valid && out_ready.
- A push and a pop in the same cycle SHALL both occur, including when the FIFO is full.
REQ-025 Minimum per-register latency is ISSUE to the next ISSUE = read-stage time + 2 cycles.

Reset
REQ-026 While reset=1, outputs SHALL be: rd_start=0, rd_addr=0, busy=0, dump_done=0, timeout_err=0, out_valid=0, out_addr=0, out_data=0.
REQ-027 While reset=1, state SHALL be IDLE and the FIFO empty.
REQ-028 Reset mid-dump SHALL abort immediately, with no dump_done pulse and FIFO contents discarded.

Configuration
REQ-029 With ADV7513_REG_DUMP_TIMEOUT_EN defined: a counter runs in WAIT.
- On reaching TIMEOUT_CYCLES, set timeout_err=1, push nothing, -> FINISH.
REQ-030 Without ADV7513_REG_DUMP_TIMEOUT_EN: no counter is built, WAIT waits indefinitely, and timeout_err is tied 0.

Structure
REQ-031 Package adv7513_pkg SHALL hold the state enum typedef, REG_ADDR_W=8, REG_DATA_W=8, and the result-entry struct {addr, data}.
REQ-032 Sub-module adv7513_dump_fifo: synchronous FWFT FIFO of result entries, parameterised by FIFO_DEPTH.

Verification
REQ-033 go, first=0x00, last=0x03; read model returns addr^0xA5; out_ready=1 -> results (00,A5),(01,A4),(02,A7),(03,A6) in order, one dump_done.
REQ-034 first=0xFE, last=0x01 -> rd_addr sequence FE, FF, 00, 01; four entries.
REQ-035 FIFO_DEPTH=4, out_ready=0, scan 0x00..0x07 -> stalls in STORE after 4 entries.
- Then release out_ready -> all 8 entries emerge in order with no loss.
REQ-036 rd_done held high from the prior read at ISSUE -> no advance until a fresh 0->1 edge.
REQ-037 With TIMEOUT_EN and TIMEOUT_CYCLES=100, rd_done never rises -> timeout_err=1 after 100 cycles, dump_done pulses, FIFO empty.
REQ-038 Assert reset in WAIT of a 16-register dump -> all outputs at reset values, no dump_done.
- A following go works normally.
